// File: rtl/jls_encode_scheduler.sv
// Merges regular-mode and run-mode JPEG-LS codes onto one bit packer. Over-limit regular codes
// are split into a limit-prefix beat and an escape-remainder beat. Frame statistics are kept too.
module jls_encode_scheduler #(
  parameter int unsigned EncW  = 32,
  parameter int unsigned LenW  = 6,
  parameter int unsigned RemW  = 9,
  parameter int unsigned Limit = 32,
  parameter int unsigned Qbpp  = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            frame_start_i,
  input  logic            reg_valid_i,
  output logic            reg_ready_o,
  input  logic [EncW-1:0] reg_code_i,
  input  logic [LenW-1:0] reg_len_i,
  input  logic            reg_ovf_i,
  input  logic [RemW-1:0] reg_rem_i,
  input  logic            run_valid_i,
  output logic            run_ready_o,
  input  logic [EncW-1:0] run_code_i,
  input  logic [LenW-1:0] run_len_i,
  output logic            pk_valid_o,
  input  logic            pk_ready_i,
  output logic [EncW-1:0] pk_code_o,
  output logic [LenW-1:0] pk_len_o,
  output logic            pk_src_o,
  output logic [31:0]     bit_count_o,
  output logic [15:0]     ovf_count_o,
  output logic            err_len_o
);

  localparam logic [LenW-1:0] PrefixLen = LenW'(Limit - Qbpp - 1);
  localparam logic [LenW-1:0] RemLen    = LenW'(Qbpp + 1);

  typedef enum logic [1:0] {StIdle, StEmitOne, StEmitPrefix, StEmitRem} state_e;

  state_e          state_q, state_d;
  logic [EncW-1:0] pk_code_q, pk_code_d;
  logic [LenW-1:0] pk_len_q, pk_len_d;
  logic            pk_src_q, pk_src_d;
  logic [RemW-1:0] rem_q, rem_d;
  logic [31:0]     bit_count_q, bit_count_d;
  logic [15:0]     ovf_count_q, ovf_count_d;
  logic            err_len_q, err_len_d;

  logic            acc_ok, run_acc, reg_acc, ovf_acc, one_acc, pk_hs;
  logic [EncW-1:0] reg_mask;
  logic [31:0]     hs_bits;
  logic [15:0]     ovf_base;

  function automatic logic len_bad(input logic [LenW-1:0] len);
    return (len == '0) || (32'(len) > EncW);
  endfunction

  // New codes are taken only when the current beat is the last one of its code and is leaving.
  assign acc_ok = (state_q == StIdle) |
                  (((state_q == StEmitOne) | (state_q == StEmitRem)) & pk_ready_i);

  // Readies are forced low while reset is asserted so nothing is offered as accepted.
  assign run_ready_o = acc_ok & rst_ni;
  assign reg_ready_o = acc_ok & ~run_valid_i & rst_ni;
  assign run_acc     = run_valid_i & run_ready_o;
  assign reg_acc     = reg_valid_i & reg_ready_o;
  assign ovf_acc     = reg_acc & reg_ovf_i;
  assign one_acc     = run_acc | (reg_acc & ~reg_ovf_i);
  assign pk_valid_o  = (state_q != StIdle);
  assign pk_hs       = pk_valid_o & pk_ready_i;

  assign reg_mask = (32'(reg_len_i) >= EncW) ? '1 : ((EncW'(1) << reg_len_i) - EncW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pk_code_q   <= '0;
      pk_len_q    <= '0;
      pk_src_q    <= 1'b0;
      rem_q       <= '0;
      bit_count_q <= '0;
      ovf_count_q <= '0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pk_code_q   <= pk_code_d;
      pk_len_q    <= pk_len_d;
      pk_src_q    <= pk_src_d;
      rem_q       <= rem_d;
      bit_count_q <= bit_count_d;
      ovf_count_q <= ovf_count_d;
      err_len_q   <= err_len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (one_acc) begin
      state_d = StEmitOne;
    end else if (ovf_acc) begin
      state_d = StEmitPrefix;
    end else begin
      unique case (state_q)
        StEmitPrefix: if (pk_ready_i) state_d = StEmitRem;
        StEmitOne,
        StEmitRem:    if (pk_ready_i) state_d = StIdle;
        default:      state_d = state_q;
      endcase
    end
  end

  always_comb begin
    pk_code_d = pk_code_q;
    pk_len_d  = pk_len_q;
    pk_src_d  = pk_src_q;
    rem_d     = rem_q;
    if (run_acc) begin
      pk_code_d = run_code_i;
      pk_len_d  = run_len_i;
      pk_src_d  = 1'b1;
    end else if (reg_acc && !reg_ovf_i) begin
      pk_code_d = reg_code_i & reg_mask;
      pk_len_d  = reg_len_i;
      pk_src_d  = 1'b0;
    end else if (ovf_acc) begin
      rem_d     = reg_rem_i;
      pk_code_d = '0;
      pk_len_d  = PrefixLen;
      pk_src_d  = 1'b0;
    end else if (state_q == StEmitPrefix && pk_ready_i) begin
      pk_code_d = EncW'(rem_q);
      pk_len_d  = RemLen;
    end else if (pk_hs) begin
      // Leaving to idle: clear the beat registers so stale data never lingers.
      pk_code_d = '0;
      pk_len_d  = '0;
      pk_src_d  = 1'b0;
    end
  end

  always_comb begin
    hs_bits     = pk_hs ? 32'(pk_len_q) : 32'd0;
    bit_count_d = frame_start_i ? hs_bits : bit_count_q + hs_bits;
    ovf_base    = frame_start_i ? 16'd0 : ovf_count_q;
    ovf_count_d = (ovf_acc && ovf_base != 16'hFFFF) ? ovf_base + 16'd1 : ovf_base;
    err_len_d   = err_len_q | (run_acc & len_bad(run_len_i)) |
                  (reg_acc & ~reg_ovf_i & len_bad(reg_len_i));
  end

  assign pk_code_o   = pk_code_q;
  assign pk_len_o    = pk_len_q;
  assign pk_src_o    = pk_src_q;
  assign bit_count_o = bit_count_q;
  assign ovf_count_o = ovf_count_q;
  assign err_len_o   = err_len_q;

endmodule
